// File: rtl/rr_grant_sequencer_pkg.sv
// Shared constants for the round-robin grant sequencer: requester count,
// select width, default hold limit and the FSM state encodings.
package rr_grant_sequencer_pkg;

  localparam int N_REQ            = 8;
  localparam int SEL_W            = 3;
  localparam int MAX_HOLD_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Width of the hold counter: enough to reach MAX_HOLD-1 plus one spare bit.
  function automatic int hold_cnt_w(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_sel_decoder_3to8.sv
// 3-to-8 one-hot decoder with enable. Output is fully defined for every code
// and forced to zero when disabled, so the decoded select is never X.
module sel_decoder_3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  // Combinational decode, zero when not enabled.
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      case (sel)
        3'd0:    onehot = 8'h01;
        3'd1:    onehot = 8'h02;
        3'd2:    onehot = 8'h04;
        3'd3:    onehot = 8'h08;
        3'd4:    onehot = 8'h10;
        3'd5:    onehot = 8'h20;
        3'd6:    onehot = 8'h40;
        3'd7:    onehot = 8'h80;
        default: onehot = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin sequencer sharing one decoded 8-way select between 8 requesters.
// One grant at a time; each grant ends on done, on request drop, or on the
// hold limit, followed by a single RELEASE cycle and an IDLE cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; rotating search from ptr picks the next requester
// GRANT   | owner holds the select; hold_cnt counts cycles held
// RELEASE | one dead cycle; ptr moves to the slot after the released owner
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int SELW     = SEL_W,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_sel,
  output logic [N-1:0]    gnt_onehot,
  output logic            forced_rel
);

  localparam int            HW        = hold_cnt_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = '1;
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  logic [1:0]      state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] owner;
  logic [HW-1:0]   hold_cnt;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] cand;

  logic            rel_normal;
  logic            rel_timeout;
  logic            rel_any;

  // Rotating priority search: first set request at ptr, ptr+1, ... ptr+N-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + SELW'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // A done or a dropped request is a normal release and takes priority over
  // the timeout, so forced_rel only reports a timeout that happened alone.
  assign rel_normal  = done || !req[owner];
  assign rel_timeout = (hold_cnt == HOLD_LAST);
  assign rel_any     = rel_normal || rel_timeout;

  // State sequencing and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt_valid  <= 1'b0;
      gnt_sel    <= '0;
      forced_rel <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          forced_rel <= 1'b0;
          if (pick_found) begin
            state     <= ST_GRANT;
            gnt_valid <= 1'b1;
            gnt_sel   <= pick_idx;
          end
        end
        ST_GRANT: begin
          if (rel_any) begin
            state      <= ST_RELEASE;
            gnt_valid  <= 1'b0;
            gnt_sel    <= '0;
            forced_rel <= rel_timeout && !rel_normal;
          end
        end
        ST_RELEASE: begin
          state      <= ST_IDLE;
          forced_rel <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          gnt_valid  <= 1'b0;
          gnt_sel    <= '0;
          forced_rel <= 1'b0;
        end
      endcase
    end
  end

  // Hold counter: cleared on a new grant, saturating count while granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
        end
        ST_GRANT: begin
          if (!rel_any && hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Owner capture on grant; pointer advances past the owner during RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      ptr   <= '0;
    end else begin
      if (state == ST_IDLE && pick_found) begin
        owner <= pick_idx;
      end
      if (state == ST_RELEASE) begin
        ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
      end
    end
  end

  sel_decoder_3to8 u_sel_decoder (
    .sel    (gnt_sel),
    .en     (gnt_valid),
    .onehot (gnt_onehot)
  );

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Scoreboard bench for rr_grant_sequencer: expected grant indices are queued
// as each scenario is driven and popped when the DUT raises gnt_valid.
module tb_rr_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_sel;
  logic [7:0] gnt_onehot;
  logic       forced_rel;

  int n_checks;
  int n_errors;

  logic [2:0] sb_q[$];
  logic [2:0] cur_exp;
  logic       prev_valid;

  rr_grant_sequencer #(
    .N        (8),
    .SELW     (3),
    .MAX_HOLD (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel),
    .gnt_onehot (gnt_onehot),
    .forced_rel (forced_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Waits for gnt_valid; returns the number of negedges waited (including the
  // one where the grant is seen). An expired bound counts as a failure.
  task automatic wait_grant(output int waited);
    waited = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      waited++;
      if (gnt_valid) return;
    end
    chk("grant_wait_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: grant start pops the expectation; otherwise outputs
  // must hold the owner or be fully zero.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [7:0] e_oh;
    if (rst_n) begin
      if (gnt_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e       = sb_q.pop_front();
          cur_exp = e;
          e_oh    = 8'h01 << e;
          chk("grant_sel", {29'd0, gnt_sel}, {29'd0, e});
          chk("grant_onehot", {24'd0, gnt_onehot}, {24'd0, e_oh});
        end
      end else if (gnt_valid) begin
        chk("hold_sel", {29'd0, gnt_sel}, {29'd0, cur_exp});
      end else begin
        chk("idle_out", {21'd0, gnt_sel, gnt_onehot}, 32'd0);
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int cnt;
    int pulses;
    n_checks   = 0;
    n_errors   = 0;
    prev_valid = 1'b0;
    cur_exp    = '0;
    rst_n      = 1'b0;
    req        = 8'h00;
    done       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("rst_sel", {29'd0, gnt_sel}, 32'd0);
    chk("rst_onehot", {24'd0, gnt_onehot}, 32'd0);
    chk("rst_forced", {31'd0, forced_rel}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rotation with all requesting: 0..7 then wrap to 0, 2 dead cycles each
    for (int k = 0; k < 9; k++) sb_q.push_back(3'(k % 8));
    req = 8'hFF;
    wait_grant(w);
    chk("rot_first_latency", w, 1);
    for (int k = 0; k < 9; k++) begin
      done = 1'b1;
      if (k == 8) req = 8'h00;
      @(negedge clk);
      done = 1'b0;
      chk("rot_release", {31'd0, gnt_valid}, 32'd0);
      chk("rot_forced", {31'd0, forced_rel}, 32'd0);
      if (k < 8) begin
        wait_grant(w);
        chk("rot_gap", w, 2);
      end
    end
    repeat (3) @(negedge clk);

    // Wrap/skip: grant 5 moves ptr to 6, then req=03 grants 0 then 1
    sb_q.push_back(3'd5);
    sb_q.push_back(3'd0);
    sb_q.push_back(3'd1);
    req = 8'h20;
    wait_grant(w);
    done = 1'b1;
    req  = 8'h03;
    @(negedge clk);
    done = 1'b0;
    wait_grant(w);
    chk("wrap_gap", w, 2);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_grant(w);
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout: req[3] held, no done -> 16 cycles, one forced_rel, re-grant 3
    sb_q.push_back(3'd3);
    sb_q.push_back(3'd3);
    req = 8'h08;
    wait_grant(w);
    cnt = 1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!gnt_valid) break;
      cnt++;
    end
    chk("to_hold_len", cnt, 16);
    chk("to_forced_set", {31'd0, forced_rel}, 32'd1);
    pulses += int'(forced_rel);
    @(negedge clk);
    chk("to_forced_clr", {31'd0, forced_rel}, 32'd0);
    pulses += int'(forced_rel);
    @(negedge clk);
    chk("to_regrant_valid", {31'd0, gnt_valid}, 32'd1);
    pulses += int'(forced_rel);
    chk("to_pulses", pulses, 1);
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
    chk("to_done_forced", {31'd0, forced_rel}, 32'd0);
    repeat (3) @(negedge clk);

    // Request drop: owner 2 drops with req[4] pending -> normal release, grant 4
    sb_q.push_back(3'd2);
    sb_q.push_back(3'd4);
    req = 8'h04;
    wait_grant(w);
    req = 8'h10;
    @(negedge clk);
    chk("drop_release", {31'd0, gnt_valid}, 32'd0);
    chk("drop_forced", {31'd0, forced_rel}, 32'd0);
    wait_grant(w);
    chk("drop_gap", w, 2);
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);

    // Done coincides with timeout on cycle 16: normal release, ptr advances
    sb_q.push_back(3'd5);
    sb_q.push_back(3'd6);
    req = 8'h20;
    wait_grant(w);
    for (int i = 2; i <= 16; i++) @(negedge clk);
    chk("sim_still_held", {31'd0, gnt_valid}, 32'd1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("sim_release", {31'd0, gnt_valid}, 32'd0);
    chk("sim_forced", {31'd0, forced_rel}, 32'd0);
    req = 8'h60;
    wait_grant(w);
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-grant with owner 5; then req=01 grants 0 one edge later
    sb_q.push_back(3'd5);
    sb_q.push_back(3'd0);
    req = 8'h20;
    wait_grant(w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("mid_rst_onehot", {24'd0, gnt_onehot}, 32'd0);
    chk("mid_rst_sel", {29'd0, gnt_sel}, 32'd0);
    req = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, gnt_valid}, 32'd1);
    chk("post_rst_onehot", {24'd0, gnt_onehot}, 32'h01);
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
